// File: rtl/sha256_msg_schedule_if.sv
`default_nettype none
// ============================================================================
//  Module      : sha256_msg_schedule_if
//  Description : Word-in / round-out stream bundle for the SHA-256 message
//                schedule generator. The slave side is the schedule block,
//                the master side is its producer and consumer.
//  Revision    : 1.0
// ============================================================================
interface sha256_msg_schedule_if;
    logic [31:0] in_word;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] out_Wi;
    logic [31:0] out_Ki;
    logic [5:0]  out_round;
    logic        out_last;
    logic        out_valid;
    logic        out_ready;

    modport master (
        output in_word, in_valid, out_ready,
        input  in_ready, out_Wi, out_Ki, out_round, out_last, out_valid
    );

    modport slave (
        input  in_word, in_valid, out_ready,
        output in_ready, out_Wi, out_Ki, out_round, out_last, out_valid
    );
endinterface
`default_nettype wire

// File: rtl/sha256_msg_schedule.sv
`default_nettype none
// ============================================================================
//  Module      : sha256_msg_schedule
//  Description : Loads one 512-bit block as 16 big-endian words, then emits
//                W0..W63 with K0..K63, one round per handshake, using a
//                16-word sliding window to expand the schedule on the fly.
//  Revision    : 1.0
// ============================================================================
module sha256_msg_schedule (
    input  wire logic             clk,
    input  wire logic             rst,
    sha256_msg_schedule_if.slave  bus
);

    typedef enum logic [0:0] {
        S_LOAD = 1'b0,
        S_EMIT = 1'b1
    } state_t;

    localparam logic [31:0] K_ROM [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic logic [31:0] sig0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
    endfunction

    function automatic logic [31:0] sig1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
    endfunction

    state_t      state_q;
    logic [3:0]  cnt_q;
    logic [5:0]  t_q;
    logic [31:0] w_q [16];
    logic [31:0] w_new_d;
    logic        in_acc;
    logic        out_acc;

    assign in_acc  = (state_q == S_LOAD) && bus.in_valid;
    assign out_acc = (state_q == S_EMIT) && bus.out_ready;

    // Next schedule word; this adder tree feeds only the top window slot.
    always_comb begin
        w_new_d = sig1(w_q[14]) + w_q[9] + sig0(w_q[1]) + w_q[0];
    end

    // Load/emit sequencing: word counter, round index and state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_LOAD;
            cnt_q   <= 4'd0;
            t_q     <= 6'd0;
        end else begin
            case (state_q)
                S_LOAD: begin
                    if (in_acc) begin
                        cnt_q <= cnt_q + 4'd1;
                        if (cnt_q == 4'd15) begin
                            state_q <= S_EMIT;
                            t_q     <= 6'd0;
                        end
                    end
                end
                S_EMIT: begin
                    if (out_acc) begin
                        t_q <= t_q + 6'd1;
                        if (t_q == 6'd63) begin
                            state_q <= S_LOAD;
                            cnt_q   <= 4'd0;
                        end
                    end
                end
                default: state_q <= S_LOAD;
            endcase
        end
    end

    // Sliding window: filled by index during load, shifted down per round.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) begin
                w_q[i] <= 32'd0;
            end
        end else if (in_acc) begin
            w_q[cnt_q] <= bus.in_word;
        end else if (out_acc) begin
            for (int i = 0; i < 15; i++) begin
                w_q[i] <= w_q[i+1];
            end
            w_q[15] <= w_new_d;
        end
    end

    // Outputs come straight from state, window head and the t-indexed ROM.
    assign bus.in_ready  = (state_q == S_LOAD);
    assign bus.out_valid = (state_q == S_EMIT);
    assign bus.out_round = t_q;
    assign bus.out_last  = (state_q == S_EMIT) && (t_q == 6'd63);
    assign bus.out_Wi    = (state_q == S_EMIT) ? w_q[0] : 32'd0;
    assign bus.out_Ki    = (state_q == S_EMIT) ? K_ROM[t_q] : 32'd0;

endmodule
`default_nettype wire

// File: tb/tb_sha256_msg_schedule.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sha256_msg_schedule
//  Description : Self-checking bench for sha256_msg_schedule against a
//                full-array SHA-256 schedule reference model.
//  Revision    : 1.0
// ============================================================================
module tb_sha256_msg_schedule;

    logic clk;
    logic rst;
    int   n_chk;
    int   n_fail;

    logic [31:0] blk   [16];
    logic [31:0] ref_w [64];
    logic [31:0] got_w [64];
    logic [31:0] K_TAB [64];

    sha256_msg_schedule_if bus ();

    sha256_msg_schedule dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Textbook schedule over the whole 64-entry array.
    task automatic build_ref();
        for (int t = 0; t < 64; t++) begin
            if (t < 16) begin
                ref_w[t] = blk[t];
            end else begin
                ref_w[t] = (rotr(ref_w[t-2], 17) ^ rotr(ref_w[t-2], 19) ^ (ref_w[t-2] >> 10))
                         + ref_w[t-7]
                         + (rotr(ref_w[t-15], 7) ^ rotr(ref_w[t-15], 18) ^ (ref_w[t-15] >> 3))
                         + ref_w[t-16];
            end
        end
    endtask

    task automatic rand_block();
        for (int i = 0; i < 16; i++) blk[i] = $urandom;
    endtask

    // Feed the 16 words of blk, optionally with ~50% idle cycles.
    task automatic load_block(input bit gaps);
        int  i;
        int  cyc;
        bit  v;
        i   = 0;
        cyc = 0;
        while (i < 16 && cyc < 500) begin
            @(negedge clk);
            cyc++;
            check($sformatf("ld_in_ready_w%0d", i), {63'd0, bus.in_ready}, 64'd1);
            check($sformatf("ld_out_valid_w%0d", i), {63'd0, bus.out_valid}, 64'd0);
            v = gaps ? 1'($urandom % 2) : 1'b1;
            bus.in_valid = v;
            bus.in_word  = v ? blk[i] : $urandom;
            @(posedge clk);
            if (v) i++;
        end
        check("ld_budget", 64'(i), 64'd16);
    endtask

    // Consume rounds; mode 0 = always ready, 1 = random ready,
    // 2 = random ready plus a 5-cycle stall at t=20.
    task automatic run_emit(input int mode, input bit garbage, input int abort_at);
        int          hs;
        int          cyc;
        int          stall;
        bit          rdy;
        bit          prev_stall;
        logic [31:0] pw;
        logic [31:0] pk;
        logic [5:0]  pr;
        hs = 0; cyc = 0; stall = 0; prev_stall = 0;
        pw = '0; pk = '0; pr = '0;
        while (hs < 64 && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            if (bus.out_valid !== 1'b1) begin
                check($sformatf("em_valid_t%0d", hs), {63'd0, bus.out_valid}, 64'd1);
                bus.in_valid = 1'b0;
                return;
            end
            if (prev_stall) begin
                check($sformatf("hold_wi_t%0d", hs), 64'(bus.out_Wi), 64'(pw));
                check($sformatf("hold_ki_t%0d", hs), 64'(bus.out_Ki), 64'(pk));
                check($sformatf("hold_rd_t%0d", hs), 64'(bus.out_round), 64'(pr));
            end
            check($sformatf("em_in_ready_t%0d", hs), {63'd0, bus.in_ready}, 64'd0);
            check($sformatf("em_round_t%0d", hs), 64'(bus.out_round), 64'(hs));
            check($sformatf("em_last_t%0d", hs), {63'd0, bus.out_last}, {63'd0, hs == 63});
            check($sformatf("em_wi_t%0d", hs), 64'(bus.out_Wi), 64'(ref_w[hs]));
            check($sformatf("em_ki_t%0d", hs), 64'(bus.out_Ki), 64'(K_TAB[hs]));
            got_w[hs] = bus.out_Wi;
            bus.in_valid = garbage;
            bus.in_word  = $urandom;
            if (hs == abort_at) begin
                rst           = 1'b1;
                bus.out_ready = 1'b1;
                bus.in_valid  = 1'b1;
                @(posedge clk);
                @(negedge clk);
                rst          = 1'b0;
                bus.in_valid = 1'b0;
                check("rst_in_ready",  {63'd0, bus.in_ready},  64'd1);
                check("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
                check("rst_out_round", 64'(bus.out_round),     64'd0);
                check("rst_out_last",  {63'd0, bus.out_last},  64'd0);
                return;
            end
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = 1'($urandom % 2);
                default: begin
                    if (hs == 20 && stall < 5) begin
                        rdy = 1'b0;
                        stall++;
                    end else begin
                        rdy = 1'($urandom % 2);
                    end
                end
            endcase
            bus.out_ready = rdy;
            prev_stall    = !rdy;
            pw = bus.out_Wi;
            pk = bus.out_Ki;
            pr = bus.out_round;
            @(posedge clk);
            if (rdy) hs++;
        end
        check("em_handshakes", 64'(hs), 64'd64);
    endtask

    initial begin
        K_TAB = '{
            32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
            32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
            32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
            32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
            32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
            32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
            32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
            32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
        };
        n_chk         = 0;
        n_fail        = 0;
        rst           = 1'b1;
        bus.in_word   = '0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_in_ready",  {63'd0, bus.in_ready},  64'd1);
        check("reset_out_valid", {63'd0, bus.out_valid}, 64'd0);
        check("reset_out_last",  {63'd0, bus.out_last},  64'd0);
        check("reset_out_round", 64'(bus.out_round),     64'd0);
        check("reset_out_wi",    64'(bus.out_Wi),        64'd0);
        check("reset_out_ki",    64'(bus.out_Ki),        64'd0);
        rst = 1'b0;

        // "abc" padded block
        for (int i = 0; i < 16; i++) blk[i] = 32'd0;
        blk[0]  = 32'h61626380;
        blk[15] = 32'h00000018;
        build_ref();
        load_block(1'b0);
        run_emit(0, 1'b0, -1);
        check("abc_w0",  64'(got_w[0]),  64'h61626380);
        check("abc_w15", 64'(got_w[15]), 64'h00000018);
        check("abc_w16", 64'(got_w[16]), 64'h61626380);
        check("abc_w17", 64'(got_w[17]), 64'h000f0000);
        @(negedge clk);
        check("abc_ready_after", {63'd0, bus.in_ready},  64'd1);
        check("abc_valid_after", {63'd0, bus.out_valid}, 64'd0);

        // Back-pressure with a fixed stall at t=20
        rand_block();
        build_ref();
        load_block(1'b0);
        run_emit(2, 1'b0, -1);

        // Same block loaded with gaps, random ready
        load_block(1'b1);
        run_emit(1, 1'b0, -1);

        // Garbage on in_valid during emit
        rand_block();
        build_ref();
        load_block(1'b1);
        run_emit(0, 1'b1, -1);

        // Reset in the middle of emit, then an all-zero block
        rand_block();
        build_ref();
        load_block(1'b0);
        run_emit(0, 1'b0, 30);
        for (int i = 0; i < 16; i++) blk[i] = 32'd0;
        build_ref();
        load_block(1'b0);
        run_emit(0, 1'b0, -1);

        // Back-to-back blocks, no idle cycles between them
        rand_block();
        build_ref();
        load_block(1'b0);
        run_emit(0, 1'b0, -1);
        rand_block();
        build_ref();
        load_block(1'b0);
        run_emit(0, 1'b0, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sha256_msg_schedule.md
# sha256_msg_schedule

Sequential SHA-256 message-schedule generator: the producer side of the round datapath's `in_Wi`/`in_Ki` inputs. It accepts one 512-bit block as 16 big-endian 32-bit words over a valid/ready stream. It then emits the 64 round words W0..W63, each paired with its round constant K0..K63, one round per handshake, to the round-logic controller. A 16-word sliding window computes W16..W63 on the fly, so no 64-word store is needed.

## Interface
- No parameters. Word width is fixed at 32 and round count at 64, as required by SHA-256.
- `clk` in 1 — sole clock; all state updates on rising edge.
- `rst` in 1 — synchronous, active-high reset.
- `in_word` in 32 — message word; words arrive in order, W0 first.
- `in_valid` in 1 — `in_word` is valid.
- `in_ready` out 1 — block can accept a word; high only in LOAD.
- `out_Wi` out 32 — schedule word for the current round.
- `out_Ki` out 32 — SHA-256 round constant for the current round.
- `out_round` out 6 — current round index t, 0..63.
- `out_last` out 1 — high with `out_valid` when t = 63.
- `out_valid` in/out: out 1 — `out_Wi`, `out_Ki`, `out_round` and `out_last` are valid.
- `out_ready` in 1 — the consumer accepts the current round.

## Operation
- Two states: LOAD and EMIT.
- LOAD:
  - `in_ready`=1, `out_valid`=0.
  - Each accepted word (`in_valid`&`in_ready`) is written into window slot w[cnt], and the 4-bit cnt is incremented.
  - Acceptance of the 16th word (cnt=15) moves to EMIT with t=0. cnt wraps to 0.
- EMIT:
  - `in_ready`=0; `in_valid` is ignored.
  - `out_valid`=1. `out_Wi`=w[0], `out_Ki`=K[t], `out_round`=t.
- On each accepted output (`out_valid`&`out_ready`):
  - The window shifts down: w[i]←w[i+1] for i=0..14.
  - The new top word is w[15]←σ1(w[14]) + w[9] + σ0(w[1]) + w[0], addition mod 2^32 (carries discarded).
  - t is incremented.
  - Acceptance at t=63 returns the block to LOAD with cnt=0. Window contents after this point are don't-care.
- Sigma functions:
  - σ0(x) = ROTR7(x) ^ ROTR18(x) ^ SHR3(x).
  - σ1(x) = ROTR17(x) ^ ROTR19(x) ^ SHR10(x).
- Window invariant: in EMIT, w[i] = W(t+i). Consequently W0..W15 are emitted exactly as loaded.
- K ROM: the 64 standard SHA-256 constants, combinationally indexed by t. For example K0=428a2f98, K1=71374491, K63=c67178f2.
- Back-pressure: while `out_ready`=0 in EMIT, every output holds its value and no state changes.
- Reset:
  - State goes to LOAD, cnt=0, t=0.
  - Outputs after reset: `in_ready`=1, `out_valid`=0, `out_last`=0, `out_round`=0. `out_Wi` and `out_Ki` are 0 while not valid.
  - Window is cleared to 0.
  - Reset mid-LOAD or mid-EMIT discards the partial block. The next accepted word is W0 of a new block.

## Timing
- Load: 16 cycles minimum, one word per cycle when `in_valid` is held high. Gaps in `in_valid` stall cnt.
- Latency: 16th word accepted at edge n gives `out_valid`=1 with t=0 from edge n, i.e. visible in cycle n+1.
- Emit: 64 cycles minimum with `out_ready` held high. `out_last` is asserted during the 64th.
- Last round accepted at edge m gives `in_ready`=1 in cycle m+1. There is no overlap between loading the next block and emitting the current one.
- Block throughput: 80 cycles per block with no stalls.
- All outputs are driven from registers or from a ROM indexed by a register. The schedule adder tree sits only in the w[15] register input path.
- Simultaneous `rst` with any handshake: reset wins, and the handshake has no effect.

## Test plan
- "abc" block: load W0=61626380, W1..W14=0, W15=00000018 with `out_ready`=1 → t=0 gives Wi=61626380 and Ki=428a2f98; t=15 gives Wi=00000018; t=16 gives Wi=61626380; t=17 gives Wi=000f0000; t=63 gives Ki=c67178f2 with `out_last`=1. The next cycle has `in_ready`=1.
- Back-pressure: hold `out_ready`=0 for 5 cycles at t=20, with random toggling elsewhere → `out_Wi`, `out_Ki` and `out_round` stay constant while stalled. The full W sequence matches a software reference model, and exactly 64 handshakes occur.
- Load gaps: drive `in_valid` with 50% random idle cycles → identical W sequence to the gap-free run. `in_ready` drops only after the 16th acceptance.
- `in_valid`=1 during EMIT with garbage data → ignored, and the W sequence is unchanged.
- Reset mid-EMIT at t=30 → the next cycle has `in_ready`=1, `out_valid`=0, `out_round`=0. A fresh all-zero block then yields W0..W63 all 00000000.
- Back-to-back: two blocks streamed consecutively → the second block's t=0 appears 16 accepted words after the first block's t=63 accept, and each block's sequence matches the reference model.
